branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- EX-stage branch/jump resolution unit, directly downstream of the branch comparator.
- Drives the comparator's BrUn select and consumes its BrEq/BrLT flags together with the decoded control-transfer type.
- Computes taken/not-taken and the target, then issues a registered PC redirect to fetch plus a multi-cycle flush of the wrong-path IF/ID slots.
- Fetch predicts not-taken, so every taken branch or jump redirects.

Parameters:
- XLEN, 32, datapath/address width.
- FLUSH_DEPTH, 2, number of younger pipeline slots killed after a redirect (range 1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX slot holds a live instruction.
- ex_stall  in  1  EX held this cycle; no resolution, flush counter frozen.
- ex_is_branch  in  1  conditional branch (B-type).
- ex_is_jal  in  1  JAL.
- ex_is_jalr  in  1  JALR.
- ex_funct3  in  3  branch condition field.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_imm  in  XLEN  sign-extended immediate.
- ex_rs1  in  XLEN  forwarded rs1 value (JALR base).
- BrEq  in  1  from comparator.
- BrLT  in  1  from comparator.
- BrUn  out  1  comparator unsigned select, combinational: 1 iff ex_funct3 is 110 or 111.
- redirect_valid  out  1  one-cycle pulse; fetch loads redirect_pc.
- redirect_pc  out  XLEN  registered target.
- flush  out  1  kill IF/ID contents; high for FLUSH_DEPTH unstalled cycles.
- misalign_exc  out  1  one-cycle pulse: taken target not 4-byte aligned.
- misalign_addr  out  XLEN  offending target, held until next exception.
- illegal_br  out  1  one-cycle pulse: branch with funct3 010/011.

Behaviour:
- Reset (async, rst_n=0): redirect_valid=0, redirect_pc=0, flush=0, misalign_exc=0, misalign_addr=0, illegal_br=0, FSM=IDLE, counter=0. Reset mid-flush aborts the flush immediately.
- Resolve condition: ex_valid & ~ex_stall & FSM==IDLE.
- Condition decode (branch only):
  - 000: taken = BrEq.
  - 001: taken = ~BrEq.
  - 100/110: taken = BrLT.
  - 101/111: taken = ~BrLT.
  - 010/011: not taken; illegal_br pulses next cycle.
- JAL/JALR are always taken.
- Target arithmetic, modulo 2^XLEN with wrap-around permitted:
  - Branch/JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) with bit0 cleared.
- One-hot violation (more than one of is_branch/is_jal/is_jalr set) is treated as not taken, no pulse.
- Latency: resolved in cycle N; redirect_valid, redirect_pc and flush all become visible at N+1.
- Misaligned case: taken with target[1:0] != 0:
  - No redirect and no flush.
  - misalign_exc pulses at N+1; misalign_addr = target.
- FSM:
  - IDLE: on a taken, aligned resolve → FLUSH, counter = FLUSH_DEPTH, redirect_valid=1 for that first cycle only.
  - FLUSH: flush=1. Counter decrements on each cycle with ex_stall=0 and holds while stalled. Counter reaching 1 with ex_stall=0 → IDLE next cycle.
- ex_valid seen during FLUSH is wrong-path; it is ignored, with no redirect, exception or pulse.
- Back-to-back: the instruction arriving in the first cycle after FLUSH exits is resolved normally.
- Not-taken or non-control instructions produce no outputs and leave the FSM in IDLE.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- When defined, adds outputs stat_branches (32), stat_taken (32) and stat_redirects (32).
  - All reset to 0 and are saturating.
  - Each increments in the cycle after a qualifying resolve (branch resolved / branch taken / redirect issued).
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - FSM state encoding (IDLE, FLUSH).
  - XLEN default.
- One natural sub-module, branch_cond_decode: combinational funct3 + BrEq/BrLT → taken, illegal, BrUn.
- Target adder, FSM and registers stay at top level.

Test Plan:
- BEQ, funct3=000, BrEq=1, pc=0x100, imm=0x20 → N+1: redirect_valid=1, redirect_pc=0x120; flush high 2 cycles; BrUn=0.
- BLTU, funct3=110, BrLT=0 → BrUn=1; no redirect, flush stays 0.
- JALR, rs1=0x2003, imm=0x4 → target 0x2006, misalign_exc=1, misalign_addr=0x2006; no redirect or flush.
- Taken branch, then ex_valid=1 taken-JAL in both flush cycles → ignored; exactly one redirect_valid pulse. Also hold ex_stall=1 for 3 cycles during flush → flush lasts 2+3 cycles.
- funct3=010 branch → illegal_br pulse at N+1, no redirect. pc=0xFFFFFFF0, imm=0x20 taken → redirect_pc=0x00000010 (wrap).
- Assert rst_n=0 asynchronously in the first FLUSH cycle → flush, redirect_valid and FSM cleared without a clock edge. With BRANCH_RESOLVE_STATS_EN defined, counters also read 0.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the EX-stage branch resolution unit: branch
// condition encodings, FSM state encoding and the default datapath width.
package branch_resolve_pkg;

   localparam int XLEN_DEF = 32;

   // B-type funct3 condition encodings (010/011 are reserved)
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // Redirect/flush sequencer states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } br_state_e;

endpackage

// File: rtl/branch_resolve_cond_decode.sv
// Combinational branch condition decode: turns funct3 plus the comparator
// flags into taken/illegal, and selects unsigned compare for BLTU/BGEU.
module branch_cond_decode
   import branch_resolve_pkg::*;
(
   input  logic [2:0] funct3_i,
   input  logic       br_eq_i,
   input  logic       br_lt_i,
   output logic       taken_o,
   output logic       illegal_o,
   output logic       br_un_o
);

   // Condition evaluation; reserved encodings are never taken
   always_comb begin
      taken_o   = 1'b0;
      illegal_o = 1'b0;
      case (funct3_i)
         F3_BEQ:           taken_o = br_eq_i;
         F3_BNE:           taken_o = ~br_eq_i;
         F3_BLT, F3_BLTU:  taken_o = br_lt_i;
         F3_BGE, F3_BGEU:  taken_o = ~br_lt_i;
         default:          illegal_o = 1'b1;
      endcase
   end

   // Unsigned comparator select goes straight back to the comparator
   always_comb begin
      br_un_o = (funct3_i == F3_BLTU) || (funct3_i == F3_BGEU);
   end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution. Fetch predicts not-taken, so every taken,
// aligned control transfer issues a registered redirect and then holds flush
// for FLUSH_DEPTH unstalled cycles. Misaligned targets raise an exception
// instead of redirecting.
// Optional feature macro: BRANCH_RESOLVE_STATS_EN adds saturating counters
// stat_branches / stat_taken / stat_redirects.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int XLEN        = XLEN_DEF,
   parameter int FLUSH_DEPTH = 2
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_stall,
   input  logic            ex_is_branch,
   input  logic            ex_is_jal,
   input  logic            ex_is_jalr,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic            BrEq,
   input  logic            BrLT,
   output logic            BrUn,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic            misalign_exc,
   output logic [XLEN-1:0] misalign_addr,
   output logic            illegal_br
`ifdef BRANCH_RESOLVE_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_taken,
   output logic [31:0]     stat_redirects
`endif
);

   br_state_e       state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic            redirect_valid_q;
   logic [XLEN-1:0] redirect_pc_q;
   logic            misalign_exc_q;
   logic [XLEN-1:0] misalign_addr_q;
   logic            illegal_q;

   logic            cond_taken, cond_illegal;
   logic [1:0]      type_cnt;
   logic            one_hot, resolve, taken, misaligned;
   logic [XLEN-1:0] sum_base, sum, target;
   logic            do_redirect, do_misalign, do_illegal;

   branch_cond_decode u_cond (
      .funct3_i  (ex_funct3),
      .br_eq_i   (BrEq),
      .br_lt_i   (BrLT),
      .taken_o   (cond_taken),
      .illegal_o (cond_illegal),
      .br_un_o   (BrUn)
   );

   // Resolution qualifiers, target adder and outcome classification
   always_comb begin
      type_cnt    = {1'b0, ex_is_branch} + {1'b0, ex_is_jal} + {1'b0, ex_is_jalr};
      one_hot     = (type_cnt == 2'd1);
      resolve     = ex_valid & ~ex_stall & (state_q == ST_IDLE);
      taken       = one_hot & ((ex_is_branch & cond_taken) | ex_is_jal | ex_is_jalr);
      sum_base    = ex_is_jalr ? ex_rs1 : ex_pc;
      sum         = sum_base + ex_imm;
      // JALR clears bit 0 of the computed address
      target      = {sum[XLEN-1:1], sum[0] & ~ex_is_jalr};
      misaligned  = (target[1:0] != 2'b00);
      do_redirect = resolve & taken & ~misaligned;
      do_misalign = resolve & taken & misaligned;
      do_illegal  = resolve & one_hot & ex_is_branch & cond_illegal;
   end

   // FSM state and flush counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state: enter FLUSH on a redirect, count down unstalled cycles
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (do_redirect) begin
               state_d = ST_FLUSH;
               cnt_d   = 3'(FLUSH_DEPTH);
            end
         end
         ST_FLUSH: begin
            if (!ex_stall) begin
               if (cnt_q <= 3'd1) begin
                  state_d = ST_IDLE;
                  cnt_d   = 3'd0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // FSM outputs: flush is asserted for the whole FLUSH state
   always_comb begin
      flush = (state_q == ST_FLUSH);
   end

   // Registered redirect / exception pulses; addresses held between events
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         misalign_exc_q   <= 1'b0;
         misalign_addr_q  <= '0;
         illegal_q        <= 1'b0;
      end else begin
         redirect_valid_q <= do_redirect;
         misalign_exc_q   <= do_misalign;
         illegal_q        <= do_illegal;
         if (do_redirect) redirect_pc_q   <= target;
         if (do_misalign) misalign_addr_q <= target;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign misalign_exc   = misalign_exc_q;
   assign misalign_addr  = misalign_addr_q;
   assign illegal_br     = illegal_q;

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] stat_br_q, stat_tk_q, stat_rd_q;
   logic        inc_br, inc_tk;

   // Statistic qualifiers: one-hot branches resolved, and those taken
   always_comb begin
      inc_br = resolve & one_hot & ex_is_branch;
      inc_tk = inc_br & cond_taken;
   end

   // Saturating event counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_br_q <= '0;
         stat_tk_q <= '0;
         stat_rd_q <= '0;
      end else begin
         if (inc_br && stat_br_q != '1)      stat_br_q <= stat_br_q + 32'd1;
         if (inc_tk && stat_tk_q != '1)      stat_tk_q <= stat_tk_q + 32'd1;
         if (do_redirect && stat_rd_q != '1) stat_rd_q <= stat_rd_q + 32'd1;
      end
   end

   assign stat_branches  = stat_br_q;
   assign stat_taken     = stat_tk_q;
   assign stat_redirects = stat_rd_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios with constant
// expectations plus a randomized run against a cycle-level behavioural model.
module tb_branch_resolve;

   localparam int XLEN  = 32;
   localparam int DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr;
   logic [2:0]      ex_funct3;
   logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1;
   logic            BrEq, BrLT, BrUn;
   logic            redirect_valid, flush, misalign_exc, illegal_br;
   logic [XLEN-1:0] redirect_pc, misalign_addr;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0]     stat_branches, stat_taken, stat_redirects;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   int              m_left;
   logic            m_rv, m_exc, m_ill;
   logic [XLEN-1:0] m_rpc, m_maddr;
   int              m_sb, m_st, m_sr;

   always #5 clk = ~clk;

   branch_resolve #(.XLEN(XLEN), .FLUSH_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_stall       (ex_stall),
      .ex_is_branch   (ex_is_branch),
      .ex_is_jal      (ex_is_jal),
      .ex_is_jalr     (ex_is_jalr),
      .ex_funct3      (ex_funct3),
      .ex_pc          (ex_pc),
      .ex_imm         (ex_imm),
      .ex_rs1         (ex_rs1),
      .BrEq           (BrEq),
      .BrLT           (BrLT),
      .BrUn           (BrUn),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .misalign_exc   (misalign_exc),
      .misalign_addr  (misalign_addr),
      .illegal_br     (illegal_br)
`ifdef BRANCH_RESOLVE_STATS_EN
      ,
      .stat_branches  (stat_branches),
      .stat_taken     (stat_taken),
      .stat_redirects (stat_redirects)
`endif
   );

   function automatic bit exp_taken(input logic [2:0] f3, input logic eq, input logic lt);
      case (f3)
         3'd0:       return eq;
         3'd1:       return !eq;
         3'd4, 3'd6: return lt;
         3'd5, 3'd7: return !lt;
         default:    return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_left = 0; m_rv = 0; m_exc = 0; m_ill = 0; m_rpc = '0; m_maddr = '0;
      m_sb = 0; m_st = 0; m_sr = 0;
   endtask

   // Advance the model across one clock edge using the currently driven inputs
   task automatic model_edge();
      int n;
      bit tk;
      logic [XLEN-1:0] tgt;
      bit busy = (m_left > 0);
      m_rv = 0; m_exc = 0; m_ill = 0;
      if (!busy && ex_valid && !ex_stall) begin
         n = int'(ex_is_branch) + int'(ex_is_jal) + int'(ex_is_jalr);
         if (n == 1) begin
            tk  = ex_is_jal || ex_is_jalr || (ex_is_branch && exp_taken(ex_funct3, BrEq, BrLT));
            tgt = ex_is_jalr ? ((ex_rs1 + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
            if (ex_is_branch) m_sb++;
            if (ex_is_branch && tk) m_st++;
            if (ex_is_branch && (ex_funct3 == 3'd2 || ex_funct3 == 3'd3)) m_ill = 1;
            if (tk) begin
               if (tgt % 4 != 0) begin
                  m_exc = 1; m_maddr = tgt;
               end else begin
                  m_rv = 1; m_rpc = tgt; m_left = DEPTH; m_sr++;
               end
            end
         end
      end else if (busy && !ex_stall) begin
         m_left--;
      end
   endtask

   task automatic drive(input logic v, input logic st, input logic br, input logic jal,
                        input logic jalr, input logic [2:0] f3, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] imm, input logic [XLEN-1:0] rs1,
                        input logic eq, input logic lt);
      ex_valid = v; ex_stall = st; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
      ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; BrEq = eq; BrLT = lt;
   endtask

   task automatic drive_idle();
      drive(0, 0, 0, 0, 0, 3'd0, '0, '0, '0, 0, 0);
   endtask

   // One clock: update model, pass the edge, settle, and log the transaction
   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      $display("txn t=%0t v=%0b st=%0b b/j/jr=%0b%0b%0b f3=%0d -> rv=%0b rpc=%h fl=%0b exc=%0b ill=%0b",
               $time, ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr, ex_funct3,
               redirect_valid, redirect_pc, flush, misalign_exc, illegal_br);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%0b exp=0", redirect_valid); end
      checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_rpc got=%h exp=0", redirect_pc); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%0b exp=0", flush); end
      checks++; if (misalign_exc !== 1'b0) begin errors++; $display("FAIL reset_exc got=%0b exp=0", misalign_exc); end
      checks++; if (misalign_addr !== 32'h0) begin errors++; $display("FAIL reset_maddr got=%h exp=0", misalign_addr); end
      checks++; if (illegal_br !== 1'b0) begin errors++; $display("FAIL reset_ill got=%0b exp=0", illegal_br); end
`ifdef BRANCH_RESOLVE_STATS_EN
      checks++; if (stat_branches !== 0 || stat_taken !== 0 || stat_redirects !== 0) begin
         errors++; $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0", stat_branches, stat_taken, stat_redirects); end
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_beq();
      drive(1, 0, 1, 0, 0, 3'd0, 32'h100, 32'h20, '0, 1, 0);
      #1;
      checks++; if (BrUn !== 1'b0) begin errors++; $display("FAIL beq_brun got=%0b exp=0", BrUn); end
      tick();
      checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_rv got=%0b exp=1", redirect_valid); end
      checks++; if (redirect_pc !== 32'h120) begin errors++; $display("FAIL beq_rpc got=%h exp=120", redirect_pc); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush1 got=%0b exp=1", flush); end
      drive_idle();
      tick();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL beq_rv_pulse got=%0b exp=0", redirect_valid); end
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush2 got=%0b exp=1", flush); end
      tick();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL beq_flush_end got=%0b exp=0", flush); end
   endtask

   task automatic test_bltu();
      drive(1, 0, 1, 0, 0, 3'd6, 32'h200, 32'h40, '0, 0, 0);
      #1;
      checks++; if (BrUn !== 1'b1) begin errors++; $display("FAIL bltu_brun got=%0b exp=1", BrUn); end
      tick();
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL bltu_rv got=%0b exp=0", redirect_valid); end
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL bltu_flush got=%0b exp=0", flush); end
      drive_idle();
      tick();
   endtask

   task automatic test_jalr_misalign();
      drive(1, 0, 0, 0, 1, 3'd0, 32'h500, 32'h4, 32'h2003, 0, 0);
      tick();
      checks++; if (misalign_exc !== 1'b1) begin errors++; $display("FAIL jalr_exc got=%0b exp=1", misalign_exc); end
      checks++; if (misalign_addr !== 32'h2006) begin errors++; $display("FAIL jalr_maddr got=%h exp=2006", misalign_addr); end
      checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin
         errors++; $display("FAIL jalr_noredir got=rv%0b/fl%0b exp=0/0", redirect_valid, flush); end
      drive_idle();
      tick();
      checks++; if (misalign_exc !== 1'b0) begin errors++; $display("FAIL jalr_exc_pulse got=%0b exp=0", misalign_exc); end
      checks++; if (misalign_addr !== 32'h2006) begin errors++; $display("FAIL jalr_maddr_hold got=%h exp=2006", misalign_addr); end
   endtask

   task automatic test_flush_ignore();
      int rv_cnt;
      int fl_cnt;
      // Wrong-path JALs during both flush cycles must be dropped
      drive(1, 0, 1, 0, 0, 3'd1, 32'h300, 32'h10, '0, 0, 0);
      tick();
      rv_cnt = int'(redirect_valid);
      fl_cnt = int'(flush);
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 1, 0, 3'd0, 32'h700, 32'h100, '0, 0, 0);
         tick();
         rv_cnt += int'(redirect_valid);
         fl_cnt += int'(flush);
      end
      checks++; if (rv_cnt !== 1) begin errors++; $display("FAIL ignore_rv_count got=%0d exp=1", rv_cnt); end
      checks++; if (fl_cnt !== 2) begin errors++; $display("FAIL ignore_flush_len got=%0d exp=2", fl_cnt); end
      checks++; if (misalign_exc !== 1'b0 || illegal_br !== 1'b0) begin
         errors++; $display("FAIL ignore_pulses got=exc%0b/ill%0b exp=0/0", misalign_exc, illegal_br); end
      // Back-to-back: first IDLE cycle resolves normally
      drive(1, 0, 0, 1, 0, 3'd0, 32'h800, 32'h40, '0, 0, 0);
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h840) begin
         errors++; $display("FAIL b2b_redirect got=rv%0b/%h exp=1/840", redirect_valid, redirect_pc); end
      // Stall 3 cycles inside the flush window: 2 + 3 flush cycles
      fl_cnt = int'(flush);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 1, 0, 3'd0, 32'h900, 32'h40, '0, 0, 0);
         tick();
         fl_cnt += int'(flush);
      end
      drive_idle();
      for (int i = 0; i < 20 && flush; i++) begin
         tick();
         fl_cnt += int'(flush);
      end
      checks++; if (fl_cnt !== 5) begin errors++; $display("FAIL stall_flush_len got=%0d exp=5", fl_cnt); end
   endtask

   task automatic test_illegal_wrap();
      drive(1, 0, 1, 0, 0, 3'd2, 32'h100, 32'h20, '0, 1, 1);
      tick();
      checks++; if (illegal_br !== 1'b1) begin errors++; $display("FAIL illegal_pulse got=%0b exp=1", illegal_br); end
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL illegal_rv got=%0b exp=0", redirect_valid); end
      drive_idle();
      tick();
      checks++; if (illegal_br !== 1'b0) begin errors++; $display("FAIL illegal_once got=%0b exp=0", illegal_br); end
      drive(1, 0, 1, 0, 0, 3'd0, 32'hFFFF_FFF0, 32'h20, '0, 1, 0);
      tick();
      checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h10) begin
         errors++; $display("FAIL wrap_redirect got=rv%0b/%h exp=1/00000010", redirect_valid, redirect_pc); end
      drive_idle();
      repeat (DEPTH) tick();
   endtask

   task automatic test_async_reset();
      drive(1, 0, 0, 1, 0, 3'd0, 32'h1000, 32'h80, '0, 0, 0);
      tick();
      drive_idle();
      checks++; if (flush !== 1'b1) begin errors++; $display("FAIL areset_pre_flush got=%0b exp=1", flush); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL areset_flush got=%0b exp=0", flush); end
      checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL areset_rv got=%0b exp=0", redirect_valid); end
      checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL areset_rpc got=%h exp=0", redirect_pc); end
`ifdef BRANCH_RESOLVE_STATS_EN
      checks++; if (stat_branches !== 0 || stat_taken !== 0 || stat_redirects !== 0) begin
         errors++; $display("FAIL areset_stats got=%0d/%0d/%0d exp=0/0/0", stat_branches, stat_taken, stat_redirects); end
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (flush !== 1'b0) begin errors++; $display("FAIL areset_fsm_idle got=%0b exp=0", flush); end
   endtask

   task automatic test_random();
      logic [2:0] f3;
      logic [XLEN-1:0] pc, imm;
      int kind;
      for (int i = 0; i < 400; i++) begin
         kind = $urandom_range(0, 9);
         f3   = 3'($urandom_range(0, 7));
         pc   = $urandom() & ((kind == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         imm  = $urandom() & ((kind == 1) ? 32'h0000_0FFE : 32'h0000_0FFC);
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
               kind < 6 || kind == 9, kind == 6 || kind == 9, kind == 7 || kind == 9,
               f3, pc, imm, $urandom(), 1'($urandom()), 1'($urandom()));
         #1;
         checks++; if (BrUn !== (f3 == 3'd6 || f3 == 3'd7)) begin
            errors++; $display("FAIL rand_brun i=%0d got=%0b f3=%0d", i, BrUn, f3); end
         tick();
         checks++; if (redirect_valid !== m_rv || flush !== (m_left > 0) || misalign_exc !== m_exc || illegal_br !== m_ill) begin
            errors++; $display("FAIL rand_pulses i=%0d got=rv%0b fl%0b exc%0b ill%0b exp=rv%0b fl%0b exc%0b ill%0b",
                               i, redirect_valid, flush, misalign_exc, illegal_br, m_rv, m_left > 0, m_exc, m_ill); end
         checks++; if (redirect_pc !== m_rpc || misalign_addr !== m_maddr) begin
            errors++; $display("FAIL rand_addr i=%0d got=%h/%h exp=%h/%h", i, redirect_pc, misalign_addr, m_rpc, m_maddr); end
`ifdef BRANCH_RESOLVE_STATS_EN
         checks++; if (stat_branches !== 32'(m_sb) || stat_taken !== 32'(m_st) || stat_redirects !== 32'(m_sr)) begin
            errors++; $display("FAIL rand_stats i=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i,
                               stat_branches, stat_taken, stat_redirects, m_sb, m_st, m_sr); end
`endif
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_beq();
      test_bltu();
      test_jalr_misalign();
      test_flush_ignore();
      test_illegal_wrap();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
